// File: rtl/ddr_beat_packer_if.sv
// Word-in / beat-out handshake bundle for ddr_beat_packer.
// Slave side is the packer; master side feeds words and drains beats.
interface ddr_beat_packer_if #(
  parameter int IN_W  = 32,
  parameter int WORDS = 8
);
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [IN_W*WORDS-1:0] out_data;
  logic [WORDS-1:0]      out_mask;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_mask, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_mask, out_last, out_valid
  );
endinterface

// File: rtl/ddr_beat_packer.sv
// Packs IN_W-bit words into WORDS-wide DDR beats with early close on in_last.
// Define BEAT_PACKER_MSB_FIRST_EN to place slot 0 in the top word of the beat.
module ddr_beat_packer #(
  parameter int IN_W  = 32,
  parameter int WORDS = 8,
  parameter int IDX_W = $clog2(WORDS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ddr_beat_packer_if.slave bus,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);
  localparam int OW = IN_W * WORDS;

  logic [IDX_W-1:0] idx_q, idx_d, pos;
  logic [OW-1:0]    fill_q, fill_d, merged;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [WORDS-1:0] mask_q, mask_d, mask_merged;
  logic [WORDS-1:0] out_mask_q, out_mask_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready, accept, complete, handoff;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign handoff  = out_valid_q & bus.out_ready;
  assign complete = accept &
    ((idx_q == IDX_W'(WORDS - 1)) | bus.in_last);

`ifdef BEAT_PACKER_MSB_FIRST_EN
  assign pos = IDX_W'(WORDS - 1) - idx_q;
`else
  assign pos = idx_q;
`endif

  // Merge the incoming word into its slot of the fill register.
  always_comb begin
    merged      = fill_q;
    mask_merged = mask_q;
    for (int k = 0; k < WORDS; k++) begin
      if (IDX_W'(k) == pos) begin
        merged[k*IN_W +: IN_W] = bus.in_data;
        mask_merged[k]         = 1'b1;
      end
    end
  end

  // Next-state: fill progress, beat completion and handoff.
  always_comb begin
    idx_d       = idx_q;
    fill_d      = fill_q;
    mask_d      = mask_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (handoff) begin
      cnt_d       = cnt_q + 1'b1;
      out_valid_d = 1'b0;
    end
    if (complete) begin
      out_data_d  = merged;
      out_mask_d  = mask_merged;
      out_last_d  = bus.in_last;
      out_valid_d = 1'b1;
      fill_d      = '0;
      mask_d      = '0;
      idx_d       = '0;
    end else if (accept) begin
      fill_d = merged;
      mask_d = mask_merged;
      idx_d  = idx_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q       <= '0;
      fill_q      <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign beat_cnt      = cnt_q;
  assign busy          = (idx_q != '0) | out_valid_q;
endmodule

// File: tb/tb_ddr_beat_packer.sv
// Directed testbench for ddr_beat_packer (IN_W=32, WORDS=8).
// Slot ordering follows BEAT_PACKER_MSB_FIRST_EN when defined.
module tb_ddr_beat_packer;
  localparam int IN_W  = 32;
  localparam int WORDS = 8;
  localparam int OW    = IN_W * WORDS;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CNT_W-1:0] beat_cnt;
  logic busy;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  logic [IN_W-1:0]  ew [WORDS];
  logic [OW-1:0]    cap_data [$];
  logic [WORDS-1:0] cap_mask [$];
  logic             cap_last [$];

  always #5 clk = ~clk;

  ddr_beat_packer_if #(.IN_W(IN_W), .WORDS(WORDS)) bus ();

  ddr_beat_packer #(
    .IN_W(IN_W), .WORDS(WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .beat_cnt(beat_cnt), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      cap_data.push_back(bus.out_data);
      cap_mask.push_back(bus.out_mask);
      cap_last.push_back(bus.out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic int pos(input int k);
`ifdef BEAT_PACKER_MSB_FIRST_EN
    return WORDS - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [OW-1:0] exp_data(input int n);
    logic [OW-1:0] r = '0;
    for (int k = 0; k < n; k++) r[pos(k)*IN_W +: IN_W] = ew[k];
    return r;
  endfunction

  function automatic logic [WORDS-1:0] exp_mask(input int n);
    logic [WORDS-1:0] r = '0;
    for (int k = 0; k < n; k++) r[pos(k)] = 1'b1;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic clear_caps;
    cap_data.delete();
    cap_mask.delete();
    cap_last.delete();
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h in_ready stayed 0", d);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin errors++;
      $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++;
    if (bus.out_mask !== '0 || bus.out_last !== 1'b0) begin errors++;
      $display("FAIL reset_mask_last got=%h/%b exp=0/0",
               bus.out_mask, bus.out_last); end
    checks++;
    if (beat_cnt !== '0) begin errors++;
      $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_busy_ready got=%b/%b exp=0/1",
               busy, bus.in_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_beat;
    logic [CNT_W-1:0] base;
    bus.out_ready = 1'b1;
    clear_caps();
    base = beat_cnt;
    for (int i = 0; i < WORDS; i++) begin
      ew[i] = IN_W'(i + 1);
      send(ew[i], 1'b0);
    end
    idle();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL full_latency out_valid=%b exp=1", bus.out_valid); end
    checks++;
    if (bus.out_data !== exp_data(WORDS)) begin errors++;
      $display("FAIL full_data got=%h exp=%h",
               bus.out_data, exp_data(WORDS)); end
    checks++;
    if (bus.out_mask !== 8'hFF || bus.out_last !== 1'b0) begin errors++;
      $display("FAIL full_mask_last got=%h/%b exp=ff/0",
               bus.out_mask, bus.out_last); end
    tick();
    checks++;
    if (beat_cnt - base !== 16'd1 || cap_data.size() != 1) begin errors++;
      $display("FAIL full_count cnt_delta=%0d beats=%0d exp=1/1",
               beat_cnt - base, cap_data.size()); end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL full_drain valid=%b busy=%b exp=0/0",
               bus.out_valid, busy); end
  endtask

  task automatic test_partial;
    bus.out_ready = 1'b1;
    ew[0] = 32'hA; ew[1] = 32'hB; ew[2] = 32'hC;
    send(ew[0], 1'b0);
    send(ew[1], 1'b0);
    send(ew[2], 1'b1);
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data(3)) begin
      errors++;
      $display("FAIL partial_data valid=%b got=%h exp=%h",
               bus.out_valid, bus.out_data, exp_data(3)); end
    checks++;
    if (bus.out_mask !== exp_mask(3) || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL partial_mask_last got=%h/%b exp=%h/1",
               bus.out_mask, bus.out_last, exp_mask(3)); end
    tick();
    ew[0] = 32'h11;
    send(ew[0], 1'b1);
    idle();
    checks++;
    if (bus.out_data !== exp_data(1) || bus.out_mask !== exp_mask(1) ||
        bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL one_word got=%h/%h/%b exp=%h/%h/1",
               bus.out_data, bus.out_mask, bus.out_last,
               exp_data(1), exp_mask(1)); end
    tick();
  endtask

  task automatic test_backpressure;
    logic [CNT_W-1:0] base;
    logic [OW-1:0] saved;
    logic [WORDS-1:0] smask;
    clear_caps();
    bus.out_ready = 1'b0;
    base = beat_cnt;
    for (int i = 0; i < WORDS; i++) begin
      ew[i] = IN_W'(32'h100 + i);
      send(ew[i], 1'b0);
    end
    saved = exp_data(WORDS);
    smask = exp_mask(WORDS);
    bus.in_valid = 1'b1; bus.in_data = 32'h200; bus.in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== saved || bus.out_mask !== smask ||
          beat_cnt !== base) begin
        errors++;
        $display("FAIL hold_cycle%0d rdy=%b vld=%b data=%h exp_data=%h",
                 c, bus.in_ready, bus.out_valid, bus.out_data, saved);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      ew[i] = IN_W'(32'h200 + i);
      send(ew[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (beat_cnt - base !== 16'd1 || cap_data.size() != 1) begin
          errors++;
          $display("FAIL bp_handoff cnt_delta=%0d beats=%0d exp=1/1",
                   beat_cnt - base, cap_data.size()); end
        else if (cap_data[0] !== saved) begin
          errors++;
          $display("FAIL bp_handoff_data got=%h exp=%h",
                   cap_data[0], saved); end
      end
    end
    idle();
    checks++;
    if (bus.out_data !== exp_data(WORDS) || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_beat got=%h exp=%h",
               bus.out_data, exp_data(WORDS)); end
    tick();
    checks++;
    if (beat_cnt - base !== 16'd2) begin errors++;
      $display("FAIL bp_count cnt_delta=%0d exp=2", beat_cnt - base); end
  endtask

  task automatic test_back_to_back;
    logic [CNT_W-1:0] base;
    logic [OW-1:0] eb [3];
    logic [OW-1:0] first;
    bus.out_ready = 1'b1;
    clear_caps();
    stalls = 0;
    base = beat_cnt;
    for (int i = 0; i < 3 * WORDS; i++) begin
      ew[i % WORDS] = IN_W'(32'h1000 + i);
      send(ew[i % WORDS], 1'b0);
      if (i % WORDS == WORDS - 1) eb[i / WORDS] = exp_data(WORDS);
    end
    idle();
    tick(); tick();
    checks++;
    if (stalls != 0) begin errors++;
      $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
    checks++;
    if (beat_cnt - base !== 16'd3 || cap_data.size() != 3) begin
      errors++;
      $display("FAIL b2b_count cnt_delta=%0d beats=%0d exp=3/3",
               beat_cnt - base, cap_data.size()); end
    else begin
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (cap_data[b] !== eb[b] || cap_mask[b] !== 8'hFF ||
            cap_last[b] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_beat%0d got=%h exp=%h", b, cap_data[b], eb[b]);
        end
      end
    end
    clear_caps();
    base = beat_cnt;
    bus.out_ready = 1'b0;
    ew[0] = 32'h77;
    send(ew[0], 1'b1);
    first = exp_data(1);
    bus.in_valid = 1'b1; bus.in_data = 32'h88; bus.in_last = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    ew[0] = 32'h88;
    send(ew[0], 1'b1);
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data(1) ||
        bus.out_mask !== exp_mask(1) || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL no_bubble vld=%b got=%h exp=%h",
               bus.out_valid, bus.out_data, exp_data(1)); end
    checks++;
    if (beat_cnt - base !== 16'd1 || cap_data.size() != 1) begin
      errors++;
      $display("FAIL no_bubble_count cnt_delta=%0d beats=%0d exp=1/1",
               beat_cnt - base, cap_data.size()); end
    else if (cap_data[0] !== first) begin
      errors++;
      $display("FAIL no_bubble_first got=%h exp=%h", cap_data[0], first);
    end
    tick();
    checks++;
    if (beat_cnt - base !== 16'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bubble_drain cnt_delta=%0d vld=%b exp=2/0",
               beat_cnt - base, bus.out_valid); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(IN_W'(32'hDEAD0000 + i), 1'b0);
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || beat_cnt !== '0) begin errors++;
      $display("FAIL midrst_clear busy=%b cnt=%0d exp=0/0",
               busy, beat_cnt); end
    clear_caps();
    for (int i = 0; i < WORDS; i++) begin
      ew[i] = IN_W'(32'h300 + i);
      send(ew[i], 1'b0);
    end
    idle();
    tick();
    checks++;
    if (cap_data.size() != 1 || beat_cnt !== 16'd1) begin errors++;
      $display("FAIL midrst_count beats=%0d cnt=%0d exp=1/1",
               cap_data.size(), beat_cnt); end
    else begin
      checks++;
      if (cap_data[0] !== exp_data(WORDS) || cap_mask[0] !== 8'hFF) begin
        errors++;
        $display("FAIL midrst_beat got=%h/%h exp=%h/ff",
                 cap_data[0], cap_mask[0], exp_data(WORDS)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_beat_packer.md
Name: ddr_beat_packer

Overview:
- Parametrised successor to the fixed 8x32-bit UART-to-DDR word assembler.
- Packs a stream of IN_W-bit words into WORDS-wide DDR write beats of IN_W*WORDS bits.
- Uses valid/ready handshakes on both sides and supports early beat termination via in_last, with a per-word valid mask.
- Sits between the UART word assembler and the DDR write-command generator.

Parameters:
- IN_W, 32, width of one input word in bits.
- WORDS, 8, input words per output beat; legal range 2..16.
- IDX_W, $clog2(WORDS), width of the slot index counter.
- CNT_W, 16, width of the emitted-beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_data  in  IN_W  input word.
- in_valid  in  1  input word valid.
- in_last  in  1  qualifies in_data; this word closes the current beat (may be partial).
- in_ready  out  1  packer can accept a word this cycle.
- out_data  out  IN_W*WORDS  packed beat.
- out_mask  out  WORDS  bit k = 1 means slot k holds a received word.
- out_last  out  1  beat was closed by in_last.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- beat_cnt  out  CNT_W  number of beats handed off (out_valid & out_ready), wrapping.
- busy  out  1  fill index nonzero or out_valid high.

Behaviour:
- Reset (rst == 0 at posedge clk): idx=0; fill register=0; fill mask=0; out_valid=0; out_data=0; out_mask=0; out_last=0; beat_cnt=0. Reset mid-beat discards partial fill and any held beat.
- State machine:
  - FILL: idx counts slots 0..WORDS-1.
  - HOLD: out_valid high. HOLD is orthogonal; FILL continues while HOLD is active.
- in_ready = ~out_valid | out_ready. This is the only combinational path (out_ready -> in_ready). No path from in_valid to in_ready.
- Accept (in_valid & in_ready):
  - Write in_data into slot idx; set mask bit idx.
  - If idx == WORDS-1 or in_last:
    - Complete the beat: out_data <= fill with the accepted word merged; out_mask <= mask with bit idx set; out_last <= in_last; out_valid <= 1.
    - Clear fill register, mask and idx to 0 next cycle.
  - Otherwise idx <= idx+1.
- Unfilled slots of a partial beat are zero in out_data, and their mask bits are 0.
- Handoff (out_valid & out_ready):
  - beat_cnt increments, wrapping at 2^CNT_W.
  - out_valid clears unless a new beat completes the same cycle, in which case out_valid stays 1 with new contents (back-to-back, no bubble).
- Latency: the last word accepted in cycle N gives out_valid=1 in cycle N+1.
- While out_valid=1 and out_ready=0:
  - in_ready=0; fill contents are frozen.
  - out_data, out_mask and out_last are held stable.
- in_last on slot WORDS-1: full beat with out_last=1, mask all ones.
- in_last on slot 0: one-word beat, mask = 1.
- Input ignored when in_valid=0; in_last is ignored unless the word is accepted.
- Throughput: one word per cycle sustained when out_ready=1.

Optional Feature:
- Macro BEAT_PACKER_MSB_FIRST_EN.
- Defined: slot 0 occupies out_data[IN_W*WORDS-1 -: IN_W], and slot k sits k words below it. out_mask bit WORDS-1-k marks slot k. This matches the existing DDR write-data ordering.
- Undefined: slot k occupies out_data[k*IN_W +: IN_W] and mask bit k (little-endian).
- Handshake and timing are identical in both builds.

Test Plan (IN_W=32, WORDS=8, macro undefined unless stated):
- Full beat: feed 0x00000001..0x00000008 back-to-back, out_ready=1 -> one beat, out_data = 0x00000008_..._00000001 (slot 0 in LSBs), out_mask=0xFF, out_last=0, beat_cnt=1, valid one cycle after 8th accept.
- Partial: 3 words 0xA,0xB,0xC with in_last on 0xC -> out_data upper 5 words zero, out_mask=0x07, out_last=1; next beat starts at slot 0.
- Backpressure: out_ready=0 after a full beat, keep in_valid=1 -> in_ready=0, out_data stable for 10 cycles; raise out_ready -> handoff, beat_cnt=1, next 8 words pack correctly.
- Back-to-back: 24 continuous words, out_ready=1 -> 3 beats, no input stall, beat_cnt=3.
- Reset mid-operation: rst=0 after 5 words, release, feed 8 words -> single beat containing only the new 8 words, mask 0xFF, beat_cnt=1.
- With BEAT_PACKER_MSB_FIRST_EN: words 1..8 -> out_data[255:224]=0x00000001, out_data[31:0]=0x00000008; 2-word last beat -> mask 0xC0.
